// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequential read/write access controller for the bitcell memory array
//
// Purpose:
//   Accepts one word-wide request at a time over a valid/ready handshake and
//   sequences the array row select, shared RW line and column input bits so
//   that a cell can only be written while RW is low with a stable selected
//   row and stable data. Every accepted request yields one rsp_valid pulse.
//
// Optional feature macro: MEM_CTRL_VERIFY_EN
//   When defined, each write is followed by a VERIFY read-back of the row.
//   rsp_rdata returns the read-back word and rsp_err flags a mismatch against
//   the written data. When undefined, rsp_err is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_rw              1 = read, 0 = write
//   req_addr, req_wdata row address and write word
//   rsp_valid           one-cycle response pulse
//   rsp_rdata, rsp_err  read data and write-verify mismatch, valid with rsp_valid
//   row_select          one-hot row select to the array
//   arr_rw              array RW line, 1 = read/hold, 0 = write
//   arr_din             array column input bits
//   arr_dout            array column output bitlines of the selected row

module mem_access_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int STROBE_CYC = 1,
    parameter int READ_CYC   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_rw,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [(1<<ADDR_W)-1:0] row_select,
    output logic                   arr_rw,
    output logic [DATA_W-1:0]      arr_din,
    input  logic [DATA_W-1:0]      arr_dout
);

    localparam int ROWS    = 1 << ADDR_W;
    localparam int MAX_CYC = (STROBE_CYC > READ_CYC) ? STROBE_CYC : READ_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_READ,
`ifdef MEM_CTRL_VERIFY_EN
        S_VERIFY,
`endif
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic [ADDR_W-1:0]  addr_q;
    logic               rw_q;
    logic               accept;
    logic               capture;
    logic               row_active;

    assign accept = req_valid && req_ready;

    // State register and per-state cycle counter. The counter is loaded with
    // (cycles - 1) on entry to a timed state and the state exits when it is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (cnt_load) begin
                cnt <= cnt_load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        arr_rw       = 1'b1;
        row_active   = 1'b0;
        capture      = 1'b0;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                row_active = 1'b1;
                cnt_load   = 1'b1;
                if (rw_q) begin
                    state_next   = S_READ;
                    cnt_load_val = CNT_W'(READ_CYC - 1);
                end else begin
                    state_next   = S_WRITE;
                    cnt_load_val = CNT_W'(STROBE_CYC - 1);
                end
            end
            S_WRITE: begin
                row_active = 1'b1;
                arr_rw     = 1'b0;
                if (cnt == '0) begin
                    state_next = S_HOLD;
                end
            end
            // RW returns high while the row is still selected so the latch
            // closes before the select line falls.
            S_HOLD: begin
                row_active = 1'b1;
`ifdef MEM_CTRL_VERIFY_EN
                state_next   = S_VERIFY;
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(READ_CYC - 1);
`else
                state_next   = S_DONE;
`endif
            end
            S_READ: begin
                row_active = 1'b1;
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = S_DONE;
                end
            end
`ifdef MEM_CTRL_VERIFY_EN
            S_VERIFY: begin
                row_active = 1'b1;
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Decoded from a single registered address, so at most one row is ever high.
    always_comb begin
        row_select = '0;
        if (row_active) begin
            row_select = ROWS'(1) << addr_q;
        end
    end

    // Request registers. arr_din is loaded only at accept so the column
    // lines stay frozen for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            rw_q    <= 1'b1;
            arr_din <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            rw_q    <= req_rw;
            arr_din <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
        end else if (capture) begin
            rsp_rdata <= arr_dout;
        end
    end

`ifdef MEM_CTRL_VERIFY_EN
    logic err_q;

    // Cleared at every accept so reads always report 0; set only by the
    // read-back at the end of VERIFY.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (capture && (state == S_VERIFY)) begin
            err_q <= (arr_dout != arr_din);
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
